// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter for block transfers between caches and memory.
// One cache owns the bus for BLOCK_SIZE_WORDS beats. A watchdog aborts the
// transfer when TIMEOUT consecutive busy cycles pass without a beat.
module bus_rr_arbiter #(
  parameter int NUM_CPUS         = 8,
  parameter int BLOCK_SIZE_WORDS = 2,
  parameter int TIMEOUT          = 25,
  parameter int IDX_W            = $clog2(NUM_CPUS)
) (
  input  logic                                  CLK,
  input  logic                                  nRST,
  input  logic [NUM_CPUS-1:0]                   req,
  input  logic                                  beat_valid,
  output logic [NUM_CPUS-1:0]                   grant,
  output logic [IDX_W-1:0]                      grant_idx,
  output logic                                  busy,
  output logic [$clog2(BLOCK_SIZE_WORDS+1)-1:0] beat_cnt,
  output logic                                  xfer_done,
  output logic                                  timeout_err
);

  localparam int BC_W = $clog2(BLOCK_SIZE_WORDS + 1);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [IDX_W-1:0] last_idx;
  logic [WD_W-1:0]  wd;
  logic [IDX_W-1:0] rr_idx;
  logic             rr_hit;
  logic [IDX_W-1:0] cand;

  // Round-robin pick: first set req bit starting just after the last owner.
  always_comb begin
    rr_idx = '0;
    rr_hit = 1'b0;
    cand   = '0;
    for (int unsigned i = 1; i <= NUM_CPUS; i++) begin
      cand = IDX_W'((32'(last_idx) + i) % 32'(NUM_CPUS));
      if (!rr_hit && req[cand]) begin
        rr_hit = 1'b1;
        rr_idx = cand;
      end
    end
  end

  // Arbitration FSM with registered grant, beat counter and watchdog.
  // A beat in the cycle the watchdog would expire takes priority over abort.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state       <= IDLE;
      grant       <= '0;
      grant_idx   <= '0;
      busy        <= 1'b0;
      beat_cnt    <= '0;
      xfer_done   <= 1'b0;
      timeout_err <= 1'b0;
      wd          <= '0;
      last_idx    <= IDX_W'(NUM_CPUS - 1);
    end else begin
      xfer_done   <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (rr_hit) begin
            state         <= BUSY;
            grant         <= '0;
            grant[rr_idx] <= 1'b1;
            grant_idx     <= rr_idx;
            busy          <= 1'b1;
            beat_cnt      <= '0;
            wd            <= '0;
          end
        end
        BUSY: begin
          if (beat_valid) begin
            wd <= '0;
            if (beat_cnt == BC_W'(BLOCK_SIZE_WORDS - 1)) begin
              state     <= IDLE;
              grant     <= '0;
              busy      <= 1'b0;
              beat_cnt  <= '0;
              last_idx  <= grant_idx;
              xfer_done <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end else if (wd == WD_W'(TIMEOUT - 1)) begin
            state       <= IDLE;
            grant       <= '0;
            busy        <= 1'b0;
            beat_cnt    <= '0;
            wd          <= '0;
            last_idx    <= grant_idx;
            timeout_err <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter: directed scenarios followed by
// randomized traffic, all compared each cycle against a transaction-level model.
module tb_bus_rr_arbiter;

  localparam int N  = 8;
  localparam int BS = 2;
  localparam int TO = 25;

  logic         CLK = 1'b0;
  logic         nRST;
  logic [N-1:0] req;
  logic         beat_valid;
  logic [N-1:0] grant;
  logic [2:0]   grant_idx;
  logic         busy;
  logic [1:0]   beat_cnt;
  logic         xfer_done;
  logic         timeout_err;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model: who owns the bus, beats moved, silent cycles, last owner.
  bit m_busy;
  int m_owner;
  int m_beats;
  int m_silent;
  int m_last;
  bit m_done;
  bit m_to;

  bus_rr_arbiter #(
    .NUM_CPUS(N),
    .BLOCK_SIZE_WORDS(BS),
    .TIMEOUT(TO)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .req(req),
    .beat_valid(beat_valid),
    .grant(grant),
    .grant_idx(grant_idx),
    .busy(busy),
    .beat_cnt(beat_cnt),
    .xfer_done(xfer_done),
    .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of the model: owner is chosen by scanning caches after the last one.
  task automatic model_step(input logic [N-1:0] r, input logic b, input logic rst_n);
    m_done = 1'b0;
    m_to   = 1'b0;
    if (!rst_n) begin
      m_busy = 1'b0; m_owner = 0; m_beats = 0; m_silent = 0; m_last = N - 1;
    end else if (!m_busy) begin
      if (r != 0) begin
        for (int i = 1; i <= N; i++) begin
          if (r[(m_last + i) % N]) begin
            m_owner = (m_last + i) % N;
            break;
          end
        end
        m_busy = 1'b1; m_beats = 0; m_silent = 0;
      end
    end else if (b) begin
      m_beats++;
      m_silent = 0;
      if (m_beats == BS) begin
        m_busy = 1'b0; m_beats = 0; m_done = 1'b1; m_last = m_owner;
      end
    end else begin
      m_silent++;
      if (m_silent == TO) begin
        m_busy = 1'b0; m_beats = 0; m_silent = 0; m_to = 1'b1; m_last = m_owner;
      end
    end
  endtask

  task automatic check_all();
    logic [N-1:0] eg;
    eg = m_busy ? (N'(1) << m_owner) : '0;
    check_val("grant", grant, eg);
    check_val("busy", busy, m_busy);
    check_val("beat_cnt", beat_cnt, m_beats);
    check_val("xfer_done", xfer_done, m_done);
    check_val("timeout_err", timeout_err, m_to);
    if (m_busy) check_val("grant_idx", grant_idx, m_owner);
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic b, input logic rst_n);
    req = r;
    beat_valid = b;
    nRST = rst_n;
    @(posedge CLK);
    model_step(r, b, rst_n);
    #1;
    check_all();
  endtask

  initial begin
    int bprob;
    logic [N-1:0] r;
    req = '0; beat_valid = 1'b0; nRST = 1'b0;
    m_busy = 1'b0; m_owner = 0; m_beats = 0; m_silent = 0; m_last = N - 1;
    m_done = 1'b0; m_to = 1'b0;

    // Reset state, then cache 0 wins first with all requesting.
    cycle(8'hFF, 1'b1, 1'b0);
    cycle(8'hFF, 1'b1, 1'b0);
    check_val("rst_grant_idx", grant_idx, 0);
    cycle(8'hFF, 1'b0, 1'b1);
    check_val("first_grant", grant, 8'h01);
    cycle(8'hFF, 1'b1, 1'b1);
    cycle(8'hFF, 1'b1, 1'b1);
    check_val("first_done", xfer_done, 1);
    cycle(8'hFF, 1'b0, 1'b1);
    check_val("second_grant", grant, 8'h02);
    cycle(8'h00, 1'b1, 1'b1);
    cycle(8'h00, 1'b1, 1'b1);
    cycle(8'h00, 1'b0, 1'b1);

    // Wrap-around: make cache 6 the last owner, then 7 beats 0, then 0.
    cycle(8'h40, 1'b0, 1'b1);
    cycle(8'h00, 1'b1, 1'b1);
    cycle(8'h00, 1'b1, 1'b1);
    cycle(8'h81, 1'b0, 1'b1);
    check_val("wrap_grant7", grant, 8'h80);
    cycle(8'h81, 1'b1, 1'b1);
    cycle(8'h81, 1'b1, 1'b1);
    cycle(8'h81, 1'b0, 1'b1);
    check_val("wrap_grant0", grant, 8'h01);

    // Watchdog expiry with no beats at all.
    for (int i = 0; i < TO; i++) cycle(8'h00, 1'b0, 1'b1);
    check_val("to_pulse", timeout_err, 1);
    check_val("to_grant", grant, 0);
    check_val("to_no_done", xfer_done, 0);
    cycle(8'h00, 1'b0, 1'b1);

    // Beat arriving in the expiry cycle wins over the watchdog.
    cycle(8'h04, 1'b0, 1'b1);
    for (int i = 0; i < TO - 1; i++) cycle(8'h00, 1'b0, 1'b1);
    cycle(8'h00, 1'b1, 1'b1);
    check_val("late_beat_cnt", beat_cnt, 1);
    check_val("late_beat_no_to", timeout_err, 0);
    cycle(8'h00, 1'b0, 1'b1);
    check_val("late_beat_busy", busy, 1);
    cycle(8'h00, 1'b1, 1'b1);

    // Requester drops after the first beat; bus stays owned until beat two.
    cycle(8'h10, 1'b0, 1'b1);
    cycle(8'h10, 1'b1, 1'b1);
    cycle(8'h00, 1'b0, 1'b1);
    check_val("drop_held", grant, 8'h10);
    cycle(8'h00, 1'b1, 1'b1);
    check_val("drop_done", xfer_done, 1);

    // Reset in the middle of a transfer.
    cycle(8'h20, 1'b0, 1'b1);
    cycle(8'h20, 1'b1, 1'b1);
    cycle(8'h20, 1'b1, 1'b0);
    check_val("midrst_grant", grant, 0);
    check_val("midrst_done", xfer_done, 0);
    check_val("midrst_idx", grant_idx, 0);
    cycle(8'h00, 1'b0, 1'b1);

    // Randomized traffic in phases of varying beat density.
    for (int p = 0; p < 25; p++) begin
      case ($urandom_range(0, 3))
        0: bprob = 0;
        1: bprob = 5;
        2: bprob = 40;
        default: bprob = 90;
      endcase
      for (int c = 0; c < 150; c++) begin
        r = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
        cycle(r, ($urandom_range(0, 99) < bprob), ($urandom_range(0, 299) != 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
